// File: rtl/air_cond_multizone.sv
// Multi-zone hysteresis thermostat: one IDLE/HEAT/COOL state machine per zone,
// each with an anti-short-cycle dwell counter, gated by a shared mode input.
module air_cond_multizone #(
  parameter int N_ZONES    = 4,
  parameter int TEMP_WIDTH = 5,
  parameter int HEAT_ON    = 18,
  parameter int SETPOINT   = 20,
  parameter int COOL_ON    = 22,
  parameter int MIN_DWELL  = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [1:0]                    mode,
  input  logic [N_ZONES*TEMP_WIDTH-1:0] temperature,
  output logic [N_ZONES-1:0]            heating,
  output logic [N_ZONES-1:0]            cooling,
  output logic [N_ZONES-1:0]            lockout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAT = 2'd1,
    COOL = 2'd2
  } zone_state_e;

  localparam logic [CNT_WIDTH-1:0]  CNT_MAX = CNT_WIDTH'(MIN_DWELL - 1);
  localparam logic [TEMP_WIDTH-1:0] HEAT_T  = TEMP_WIDTH'(HEAT_ON);
  localparam logic [TEMP_WIDTH-1:0] SET_T   = TEMP_WIDTH'(SETPOINT);
  localparam logic [TEMP_WIDTH-1:0] COOL_T  = TEMP_WIDTH'(COOL_ON);

  // The thresholds must be strictly ordered so engage conditions never overlap.
  generate
    if (!(HEAT_ON < SETPOINT && SETPOINT < COOL_ON && MIN_DWELL >= 1 &&
          (MIN_DWELL - 1) < (2 ** CNT_WIDTH))) begin : g_param_check
      $error("air_cond_multizone: illegal threshold or dwell parameters");
    end
  endgenerate

  logic heat_ok;
  logic cool_ok;

  assign heat_ok = mode[0];
  assign cool_ok = mode[1];

  for (genvar z = 0; z < N_ZONES; z++) begin : g_zone
    zone_state_e           state_q;
    zone_state_e           state_d;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [CNT_WIDTH-1:0]  cnt_d;
    logic [TEMP_WIDTH-1:0] temp;
    logic                  expired;

    assign temp    = temperature[z*TEMP_WIDTH +: TEMP_WIDTH];
    assign expired = (cnt_q == CNT_MAX);

    // Losing mode permission drops an active zone at once; all else waits on dwell.
    always_comb begin
      state_d = state_q;
      case (state_q)
        IDLE: begin
          if (expired) begin
            if (temp <= HEAT_T && heat_ok)      state_d = HEAT;
            else if (temp >= COOL_T && cool_ok) state_d = COOL;
          end
        end
        HEAT: begin
          if (!heat_ok)                        state_d = IDLE;
          else if (expired && temp >= SET_T)   state_d = IDLE;
        end
        COOL: begin
          if (!cool_ok)                        state_d = IDLE;
          else if (expired && temp <= SET_T)   state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase

      if (state_d != state_q) cnt_d = '0;
      else if (expired)       cnt_d = cnt_q;
      else                    cnt_d = cnt_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q <= IDLE;
        cnt_q   <= CNT_MAX;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    assign heating[z] = (state_q == HEAT);
    assign cooling[z] = (state_q == COOL);
    assign lockout[z] = (state_q == IDLE) && !expired;
  end

endmodule
